// File: rtl/add_accumulator.sv
// Frame accumulator wrapped around an external ripple-carry adder.
// Sums LEN samples per frame and reports the total plus carry-out count.
`timescale 1ns/1ps
module add_accumulator #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic [LEN_W-1:0] res_carries,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [LEN_W-1:0] remaining, rem_nx;
  logic [LEN_W-1:0] carries, car_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      carries   <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      remaining <= rem_nx;
      carries   <= car_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    rem_nx   = remaining;
    car_nx   = carries;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nx   = '0;
          car_nx   = '0;
          rem_nx   = len;
          state_nx = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_nx = add_sum;
          rem_nx = remaining - 1'b1;
          if (add_cout && (carries != '1))
            car_nx = carries + 1'b1;
          if (remaining == LEN_W'(1))
            state_nx = DONE;
        end
      end
      DONE: begin
        if (res_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Adder loop is combinational: sum is captured in the accept cycle.
  assign add_a   = acc;
  assign add_b   = in_data;
  assign add_cin = 1'b0;

  assign in_ready    = (state == ACC);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign res_sum     = res_valid ? acc : '0;
  assign res_carries = res_valid ? carries : '0;

endmodule
